fll_clk_gate_ctrl: RTL and testbench
====================================

FLL_CLK_GATE_CTRL -- requirements
Module: fll_clk_gate_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of the settle and drain delay counters.
REQ-002 Parameter RESET_ON, default 1'b1, selects whether the clock is enabled after reset.
REQ-003 Parameter STAT_W, default 32, width of the off-cycle statistics counter.
REQ-004 clk_i  input  1  free-running (ungated) clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 clk_req_i  input  1  level request from the power manager: 1 = clock wanted on.
REQ-007 busy_i  input  1  consumer-domain activity flag; gating off is blocked while high.
REQ-008 on_settle_i  input  CNT_W  extra cycles between enable and acknowledge.
REQ-009 off_delay_i  input  CNT_W  idle cycles required before the clock is disabled.
REQ-010 stat_clr_i  input  1  synchronous clear of the off-cycle counter.
REQ-011 clk_en_o  output  1  registered enable, driven to the en_i pin of fll_clk_gate_wrapper.
REQ-012 clk_ack_o  output  1  registered four-phase acknowledge; follows clk_req_i once the transition completes.
REQ-013 state_o  output  2  current FSM state encoding.
REQ-014 off_cycles_o  output  STAT_W  saturating count of cycles with clk_en_o=0.

Function
REQ-015 FSM states: OFF=2'd0, WAKE=2'd1, ON=2'd2, DRAIN=2'd3. Outputs are decoded from registered state: en=0/1/1/1 and ack=0/0/1/1.
REQ-016 OFF: clk_req_i=1 moves the FSM to WAKE and loads cnt with on_settle_i; otherwise the FSM holds.
REQ-017 WAKE: clk_req_i=0 moves the FSM to DRAIN and loads cnt with off_delay_i. Otherwise cnt==0 moves it to ON, and any other cnt value decrements cnt.
REQ-018 ON: clk_req_i=0 moves the FSM to DRAIN and loads cnt with off_delay_i; otherwise the FSM holds.
REQ-019 DRAIN: clk_req_i=1 returns the FSM to ON without disabling the clock. Otherwise busy_i=1 reloads cnt with off_delay_i. Otherwise cnt==0 moves it to OFF, and any other cnt value decrements cnt.
REQ-020 Latency, clock on: clk_req_i sampled high at edge k in OFF gives clk_en_o=1 after edge k and clk_ack_o=1 after edge k+on_settle_i+1.
REQ-021 Latency, clock off: clk_req_i sampled low at edge k in ON, with busy_i=0 throughout, gives clk_en_o=0 and clk_ack_o=0 after edge k+off_delay_i+1.
REQ-022 Simultaneous busy_i=1 and clk_req_i=1 in DRAIN: the request wins and the FSM goes to ON.
REQ-023 on_settle_i and off_delay_i are sampled only at load or reload. Changes mid-count do not affect the running count.
REQ-024 clk_en_o is a flop output with no combinational path from any input, so it is glitch-free at the gate latch.
REQ-025 off_cycles_o increments each cycle that clk_en_o=0 and saturates at all-ones without wrapping.
REQ-026 stat_clr_i has priority over increment and sets off_cycles_o to 0 on the next edge.

Reset
REQ-027 When rst_i=1 at an edge: state becomes ON if RESET_ON=1, otherwise OFF. cnt becomes 0 and off_cycles_o becomes 0.
REQ-028 Reset values: clk_en_o=RESET_ON, clk_ack_o=RESET_ON, state_o=2'd2 (RESET_ON=1) or 2'd0 (RESET_ON=0).
REQ-029 Reset asserted during WAKE or DRAIN aborts the transition immediately. No count is preserved.

Structure
REQ-030 Package fll_clk_pkg holds the state enum type, the state encodings and the default CNT_W and STAT_W constants.
REQ-031 One sub-module, fll_clk_sat_cnt, implements the saturating clearable counter parameterised by width.
REQ-032 fll_clk_gate_ctrl contains no clock gating or latches. The gate cell remains external.

Verification
REQ-033 RESET_ON=1, reset, no request: bench sets clk_req_i=0 at cycle 5, off_delay_i=3, busy_i=0 -> clk_en_o and clk_ack_o fall after edge 5+4.
REQ-034 From OFF, on_settle_i=2, clk_req_i rises at edge 10 -> clk_en_o=1 after edge 10 and clk_ack_o=1 after edge 13.
REQ-035 DRAIN, off_delay_i=4, busy_i pulses high on cycle 2 of drain -> cnt reloads and OFF is reached 5 edges after busy_i falls.
REQ-036 clk_req_i re-asserted during DRAIN -> FSM goes to ON, clk_en_o never drops, clk_ack_o stays 1.
REQ-037 STAT_W=4, clock held off for 20 cycles -> off_cycles_o saturates at 15. stat_clr_i together with increment -> 0.
REQ-038 rst_i pulsed mid-WAKE with RESET_ON=0 -> state_o=0, clk_en_o=0 on the next cycle.

Source files
------------

// File: rtl/fll_clk_pkg.sv
// Shared types and defaults for the FLL clock-gate controller.
// State encodings are fixed because state_o exposes them directly.
package fll_clk_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } fll_state_e;

    localparam int unsigned FLL_CNT_W_DEF  = 8;
    localparam int unsigned FLL_STAT_W_DEF = 32;

    function automatic logic state_en(fll_state_e s);
        return (s != ST_OFF);
    endfunction

    function automatic logic state_ack(fll_state_e s);
        return (s == ST_ON) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/fll_clk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
// Holds at all-ones instead of wrapping.
module fll_clk_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fll_clk_gate_ctrl.sv
// Enable/acknowledge sequencer for an external FLL clock gate, with off-cycle statistics.
// state | meaning
// OFF   | clock disabled, ack low
// WAKE  | clock enabled, waiting on_settle cycles before ack
// ON    | clock enabled and acknowledged
// DRAIN | request dropped, waiting off_delay idle cycles before disabling
module fll_clk_gate_ctrl
    import fll_clk_pkg::*;
#(
    parameter int unsigned CNT_W    = FLL_CNT_W_DEF,
    parameter logic        RESET_ON = 1'b1,
    parameter int unsigned STAT_W   = FLL_STAT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clk_req_i,
    input  logic              busy_i,
    input  logic [CNT_W-1:0]  on_settle_i,
    input  logic [CNT_W-1:0]  off_delay_i,
    input  logic              stat_clr_i,
    output logic              clk_en_o,
    output logic              clk_ack_o,
    output logic [1:0]        state_o,
    output logic [STAT_W-1:0] off_cycles_o
);

    localparam fll_state_e RST_STATE = RESET_ON ? ST_ON : ST_OFF;

    fll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, ack_q;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_OFF: begin
                if (clk_req_i) begin
                    state_d = ST_WAKE;
                    cnt_d   = on_settle_i;
                end
            end
            ST_WAKE: begin
                if (!clk_req_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = off_delay_i;
                end else if (cnt_zero) begin
                    state_d = ST_ON;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ON: begin
                if (!clk_req_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = off_delay_i;
                end
            end
            ST_DRAIN: begin
                // A returning request beats busy so the clock never blips off.
                if (clk_req_i) begin
                    state_d = ST_ON;
                end else if (busy_i) begin
                    cnt_d = off_delay_i;
                end else if (cnt_zero) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // en/ack are flopped from the next state so the gate latch sees a clean flop output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            en_q    <= RESET_ON;
            ack_q   <= RESET_ON;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= state_en(state_d);
            ack_q   <= state_ack(state_d);
        end
    end

    fll_clk_sat_cnt #(
        .W (STAT_W)
    ) u_off_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (stat_clr_i),
        .inc_i (~en_q),
        .cnt_o (off_cycles_o)
    );

    assign clk_en_o  = en_q;
    assign clk_ack_o = ack_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_fll_clk_gate_ctrl.sv
// Directed bench for fll_clk_gate_ctrl: instance A uses defaults (RESET_ON=1),
// instance B uses RESET_ON=0 and a 4-bit statistics counter.
module tb_fll_clk_gate_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, req_a, busy_a, clr_a;
    logic [7:0] settle_a, delay_a;
    logic       en_a, ack_a;
    logic [1:0] st_a;
    logic [31:0] off_a;

    logic       rst_b, req_b, busy_b, clr_b;
    logic [7:0] settle_b, delay_b;
    logic       en_b, ack_b;
    logic [1:0] st_b;
    logic [3:0] off_b;

    int vec = 0;
    int err = 0;

    fll_clk_gate_ctrl dut_a (
        .clk_i        (clk),
        .rst_i        (rst_a),
        .clk_req_i    (req_a),
        .busy_i       (busy_a),
        .on_settle_i  (settle_a),
        .off_delay_i  (delay_a),
        .stat_clr_i   (clr_a),
        .clk_en_o     (en_a),
        .clk_ack_o    (ack_a),
        .state_o      (st_a),
        .off_cycles_o (off_a)
    );

    fll_clk_gate_ctrl #(
        .CNT_W    (8),
        .RESET_ON (1'b0),
        .STAT_W   (4)
    ) dut_b (
        .clk_i        (clk),
        .rst_i        (rst_b),
        .clk_req_i    (req_b),
        .busy_i       (busy_b),
        .on_settle_i  (settle_b),
        .off_delay_i  (delay_b),
        .stat_clr_i   (clr_b),
        .clk_en_o     (en_b),
        .clk_ack_o    (ack_b),
        .state_o      (st_b),
        .off_cycles_o (off_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string name, input logic en_x, input logic ack_x, input logic [1:0] st_x);
        vec++;
        if (en_a !== en_x || ack_a !== ack_x || st_a !== st_x) begin
            err++;
            $display("FAIL %s: got en=%b ack=%b st=%0d, exp en=%b ack=%b st=%0d",
                     name, en_a, ack_a, st_a, en_x, ack_x, st_x);
        end
    endtask

    task automatic test_reset;
        rst_a = 1'b1; req_a = 1'b1; busy_a = 1'b0; clr_a = 1'b0; settle_a = 8'd0; delay_a = 8'd3;
        rst_b = 1'b1; req_b = 1'b0; busy_b = 1'b0; clr_b = 1'b0; settle_b = 8'd0; delay_b = 8'd0;
        tick(2);
        check_a("reset_a", 1'b1, 1'b1, 2'd2);
        vec++;
        if (off_a !== 32'd0) begin
            err++; $display("FAIL reset_a_off: got %0d exp 0", off_a);
        end
        vec++;
        if (en_b !== 1'b0 || ack_b !== 1'b0 || st_b !== 2'd0 || off_b !== 4'd0) begin
            err++; $display("FAIL reset_b: got en=%b ack=%b st=%0d off=%0d exp 0 0 0 0", en_b, ack_b, st_b, off_b);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    // req drops so it is sampled at edge 5; off must appear after edge 9.
    task automatic test_off_latency;
        tick(4);
        check_a("on_hold", 1'b1, 1'b1, 2'd2);
        req_a = 1'b0;
        tick(4);
        check_a("drain_edge8", 1'b1, 1'b1, 2'd3);
        tick(1);
        check_a("off_edge9", 1'b0, 1'b0, 2'd0);
    endtask

    task automatic test_on_latency;
        clr_a = 1'b1;
        tick(1);
        vec++;
        if (off_a !== 32'd0) begin
            err++; $display("FAIL stat_clr_a: got %0d exp 0", off_a);
        end
        clr_a = 1'b0;
        tick(3);
        vec++;
        if (off_a !== 32'd3) begin
            err++; $display("FAIL stat_count_a: got %0d exp 3", off_a);
        end
        settle_a = 8'd2;
        req_a = 1'b1;
        tick(1);
        check_a("wake_en", 1'b1, 1'b0, 2'd1);
        tick(2);
        check_a("wake_noack", 1'b1, 1'b0, 2'd1);
        tick(1);
        check_a("ack_edge_k3", 1'b1, 1'b1, 2'd2);
        vec++;
        if (off_a !== 32'd4) begin
            err++; $display("FAIL stat_stop_a: got %0d exp 4", off_a);
        end
    endtask

    task automatic test_busy_reload;
        delay_a = 8'd4;
        req_a = 1'b0;
        tick(1);
        check_a("drain_enter", 1'b1, 1'b1, 2'd3);
        tick(1);
        busy_a = 1'b1;
        tick(1);
        busy_a = 1'b0;
        delay_a = 8'd9;
        tick(4);
        check_a("drain_reloaded", 1'b1, 1'b1, 2'd3);
        tick(1);
        check_a("off_after_busy", 1'b0, 1'b0, 2'd0);
        delay_a = 8'd4;
        settle_a = 8'd0;
        req_a = 1'b1;
        tick(2);
        check_a("rewake_zero_settle", 1'b1, 1'b1, 2'd2);
    endtask

    task automatic test_drain_reassert;
        req_a = 1'b0;
        tick(1);
        check_a("drain2_enter", 1'b1, 1'b1, 2'd3);
        tick(1);
        req_a = 1'b1;
        busy_a = 1'b1;
        tick(1);
        check_a("req_beats_busy", 1'b1, 1'b1, 2'd2);
        busy_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check_a("stay_on", 1'b1, 1'b1, 2'd2);
        end
    endtask

    task automatic test_stat_sat;
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;
        vec++;
        if (off_b !== 4'd0) begin
            err++; $display("FAIL stat_clr_b: got %0d exp 0", off_b);
        end
        tick(14);
        vec++;
        if (off_b !== 4'd14) begin
            err++; $display("FAIL stat_b_14: got %0d exp 14", off_b);
        end
        tick(1);
        vec++;
        if (off_b !== 4'd15) begin
            err++; $display("FAIL stat_b_15: got %0d exp 15", off_b);
        end
        tick(5);
        vec++;
        if (off_b !== 4'd15) begin
            err++; $display("FAIL stat_b_sat: got %0d exp 15", off_b);
        end
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;
        vec++;
        if (off_b !== 4'd0) begin
            err++; $display("FAIL stat_b_clr_pri: got %0d exp 0", off_b);
        end
    endtask

    task automatic test_reset_mid_wake;
        settle_b = 8'd5;
        req_b = 1'b1;
        tick(1);
        vec++;
        if (st_b !== 2'd1 || en_b !== 1'b1 || ack_b !== 1'b0) begin
            err++; $display("FAIL wake_b: got st=%0d en=%b ack=%b exp st=1 en=1 ack=0", st_b, en_b, ack_b);
        end
        tick(1);
        rst_b = 1'b1;
        tick(1);
        vec++;
        if (st_b !== 2'd0 || en_b !== 1'b0 || ack_b !== 1'b0 || off_b !== 4'd0) begin
            err++; $display("FAIL rst_mid_wake: got st=%0d en=%b ack=%b off=%0d exp 0 0 0 0", st_b, en_b, ack_b, off_b);
        end
        rst_b = 1'b0;
        req_b = 1'b0;
        tick(1);
        vec++;
        if (st_b !== 2'd0 || en_b !== 1'b0) begin
            err++; $display("FAIL post_rst_off: got st=%0d en=%b exp st=0 en=0", st_b, en_b);
        end
    endtask

    initial begin
        test_reset();
        test_off_latency();
        test_on_latency();
        test_busy_reload();
        test_drain_reassert();
        test_stat_sat();
        test_reset_mid_wake();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
